// File: rtl/pll_phase_stepper_if.sv
// Command handshake and PLL dynamic phase-shift signals for pll_phase_stepper.
// slave is the stepper side; master is the CPU/PLL side.
interface pll_phase_stepper_if;
   logic cmd_valid;
   logic cmd_dir;
   logic cmd_ready;
   logic phasestep;
   logic phaseupdown;
   logic phasedone;

   modport slave (
      input  cmd_valid,
      input  cmd_dir,
      input  phasedone,
      output cmd_ready,
      output phasestep,
      output phaseupdown
   );

   modport master (
      output cmd_valid,
      output cmd_dir,
      output phasedone,
      input  cmd_ready,
      input  phasestep,
      input  phaseupdown
   );
endinterface

// File: rtl/pll_phase_stepper.sv
// Drives the PLL dynamic phase-shift port from auto (phase detector) and manual (CPU) requests,
// tracking the absolute phase position modulo one clock period.
module pll_phase_stepper #(
   parameter int unsigned STEPS   = 40,
   parameter int unsigned POS_W   = 6,
   parameter int unsigned HOLD    = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 shift,
   input  logic                 clr_flags,
   pll_phase_stepper_if.slave   bus,
   output logic [POS_W-1:0]     position,
   output logic                 busy,
   output logic                 overrun,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {StIdle, StStep, StWaitLo, StWaitHi} state_e;

   localparam int unsigned      HoldW    = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);
   localparam logic [7:0]       TmoLast  = 8'(TIMEOUT - 1);
   localparam logic [POS_W-1:0] PosLast  = POS_W'(STEPS - 1);

   state_e           state_q;
   logic             pd_meta_q;
   logic             pd_sync_q;
   logic             auto_pend_q;
   logic             man_pend_q;
   logic             man_dir_q;
   logic             phasestep_q;
   logic             phaseupdown_q;
   logic [HoldW-1:0] hold_cnt_q;
   logic [7:0]       tmo_cnt_q;
   logic [POS_W-1:0] position_q;
   logic             overrun_q;
   logic             timeout_q;

   logic in_idle;
   logic take_man;
   logic take_auto;
   logic auto_req;
   logic man_accept;
   logic drop;
   logic tmo_hit;
   logic timeout_set;

   always_comb begin
      in_idle     = (state_q == StIdle);
      take_man    = in_idle && man_pend_q;
      take_auto   = in_idle && !man_pend_q && auto_pend_q;
      auto_req    = shift && enable;
      man_accept  = bus.cmd_valid && in_idle && !man_pend_q;
      // A new auto request only collides if the pending one is not leaving this cycle.
      drop        = auto_req && auto_pend_q && !take_auto;
      tmo_hit     = (tmo_cnt_q == TmoLast);
      timeout_set = tmo_hit && (((state_q == StWaitLo) && pd_sync_q) ||
                                ((state_q == StWaitHi) && !pd_sync_q));
   end

   // phasedone is asynchronous to clk; idle level of the PLL is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pd_meta_q <= 1'b1;
         pd_sync_q <= 1'b1;
      end else begin
         pd_meta_q <= bus.phasedone;
         pd_sync_q <= pd_meta_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         auto_pend_q <= 1'b0;
         man_pend_q  <= 1'b0;
         man_dir_q   <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         if (auto_req) begin
            auto_pend_q <= 1'b1;
         end else if (take_auto) begin
            auto_pend_q <= 1'b0;
         end
         if (man_accept) begin
            man_pend_q <= 1'b1;
            man_dir_q  <= bus.cmd_dir;
         end else if (take_man) begin
            man_pend_q <= 1'b0;
         end
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (clr_flags) begin
            overrun_q <= 1'b0;
         end
         if (timeout_set) begin
            timeout_q <= 1'b1;
         end else if (clr_flags) begin
            timeout_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         phasestep_q   <= 1'b0;
         phaseupdown_q <= 1'b0;
         hold_cnt_q    <= '0;
         tmo_cnt_q     <= '0;
         position_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (man_pend_q || auto_pend_q) begin
                  phaseupdown_q <= man_pend_q ? man_dir_q : 1'b1;
                  phasestep_q   <= 1'b1;
                  hold_cnt_q    <= '0;
                  state_q       <= StStep;
               end
            end
            StStep: begin
               if (hold_cnt_q == HoldLast) begin
                  phasestep_q <= 1'b0;
                  tmo_cnt_q   <= '0;
                  state_q     <= StWaitLo;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            StWaitLo: begin
               if (!pd_sync_q) begin
                  tmo_cnt_q <= '0;
                  state_q   <= StWaitHi;
               end else if (tmo_hit) begin
                  state_q <= StIdle;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            StWaitHi: begin
               if (pd_sync_q) begin
                  if (phaseupdown_q) begin
                     position_q <= (position_q == PosLast) ? '0 : position_q + POS_W'(1);
                  end else begin
                     position_q <= (position_q == '0) ? PosLast : position_q - POS_W'(1);
                  end
                  state_q <= StIdle;
               end else if (tmo_hit) begin
                  state_q <= StIdle;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.phasestep   = phasestep_q;
   assign bus.phaseupdown = phaseupdown_q;
   assign bus.cmd_ready   = in_idle && !man_pend_q;
   assign position        = position_q;
   assign busy            = !in_idle;
   assign overrun         = overrun_q;
   assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper with a behavioural PLL phasedone model.
module tb_pll_phase_stepper;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       shift;
   logic       clr_flags;
   logic [5:0] position;
   logic       busy;
   logic       overrun;
   logic       timeout_err;
   logic       pll_dead;
   int         checks;
   int         errors;
   int         exp_pos;

   pll_phase_stepper_if pif ();

   pll_phase_stepper #(
      .STEPS   (40),
      .POS_W   (6),
      .HOLD    (2),
      .TIMEOUT (255)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .shift       (shift),
      .clr_flags   (clr_flags),
      .bus         (pif.slave),
      .position    (position),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PLL: phasedone drops 3 cycles after the phasestep rise and stays low for 5 cycles.
   always begin
      @(posedge pif.phasestep);
      if (!pll_dead) begin
         repeat (3) @(posedge clk);
         #1 pif.phasedone = 1'b0;
         repeat (5) @(posedge clk);
         #1 pif.phasedone = 1'b1;
      end
   end

   task automatic pulse_shift();
      @(negedge clk);
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
   endtask

   task automatic send_cmd(input logic dir);
      @(negedge clk);
      pif.cmd_valid = 1'b1;
      pif.cmd_dir   = dir;
      @(negedge clk);
      pif.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 600) begin
         @(negedge clk);
         n++;
      end
      ok = !busy;
   endtask

   task automatic wait_step(output bit ok);
      int n;
      n = 0;
      while (!pif.phasestep && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = pif.phasestep;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (pif.phasestep !== 1'b0) begin
         $display("FAIL reset_phasestep: got %b expected 0", pif.phasestep); errors++;
      end
      checks++;
      if (pif.phaseupdown !== 1'b0) begin
         $display("FAIL reset_phaseupdown: got %b expected 0", pif.phaseupdown); errors++;
      end
      checks++;
      if (position !== 6'd0) begin
         $display("FAIL reset_position: got %0d expected 0", position); errors++;
      end
      checks++;
      if (busy !== 1'b0 || overrun !== 1'b0 || timeout_err !== 1'b0) begin
         $display("FAIL reset_flags: got busy=%b ovr=%b tmo=%b expected 000",
                  busy, overrun, timeout_err); errors++;
      end
      checks++;
      if (pif.cmd_ready !== 1'b1) begin
         $display("FAIL reset_cmd_ready: got %b expected 1", pif.cmd_ready); errors++;
      end
   endtask

   task automatic test_auto_single();
      pulse_shift();
      checks++;
      if (pif.phasestep !== 1'b0) begin
         $display("FAIL auto_latency_early: got %b expected 0", pif.phasestep); errors++;
      end
      @(negedge clk);
      checks++;
      if (pif.phasestep !== 1'b1 || pif.phaseupdown !== 1'b1) begin
         $display("FAIL auto_step_rise: got step=%b dir=%b expected 11",
                  pif.phasestep, pif.phaseupdown); errors++;
      end
      @(negedge clk);
      checks++;
      if (pif.phasestep !== 1'b1) begin
         $display("FAIL auto_step_hold: got %b expected 1", pif.phasestep); errors++;
      end
      @(negedge clk);
      checks++;
      if (pif.phasestep !== 1'b0) begin
         $display("FAIL auto_step_fall: got %b expected 0", pif.phasestep); errors++;
      end
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         $display("FAIL auto_busy_before_sync: got %b expected 1", busy); errors++;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || position !== 6'd1) begin
         $display("FAIL auto_done: got busy=%b pos=%0d expected busy=0 pos=1", busy, position);
         errors++;
      end
      exp_pos = 1;
   endtask

   task automatic test_wrap();
      bit ok;
      for (int i = 0; i < 39; i++) begin
         pulse_shift();
         wait_idle(ok);
         checks++;
         if (!ok) begin
            $display("FAIL wrap_wait: got busy after bound expected idle (step %0d)", i); errors++;
         end
         exp_pos = (exp_pos + 1) % 40;
         if (i == 37) begin
            checks++;
            if (position !== 6'd39) begin
               $display("FAIL wrap_top: got %0d expected 39", position); errors++;
            end
         end
      end
      checks++;
      if (position !== 6'd0) begin
         $display("FAIL wrap_zero: got %0d expected 0", position); errors++;
      end
      send_cmd(1'b0);
      wait_idle(ok);
      checks++;
      if (!ok || position !== 6'd39) begin
         $display("FAIL wrap_down: got pos=%0d ok=%b expected 39", position, ok); errors++;
      end
      send_cmd(1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || position !== 6'd0) begin
         $display("FAIL wrap_up: got pos=%0d ok=%b expected 0", position, ok); errors++;
      end
      exp_pos = 0;
   endtask

   task automatic test_arbitration();
      bit ok;
      @(negedge clk);
      shift = 1'b1;
      pif.cmd_valid = 1'b1;
      pif.cmd_dir = 1'b0;
      @(negedge clk);
      pif.cmd_valid = 1'b0;
      @(negedge clk);
      shift = 1'b0;
      checks++;
      if (pif.phasestep !== 1'b1 || pif.phaseupdown !== 1'b0) begin
         $display("FAIL arb_manual_first: got step=%b dir=%b expected 10",
                  pif.phasestep, pif.phaseupdown); errors++;
      end
      wait_idle(ok);
      checks++;
      if (!ok || overrun !== 1'b1) begin
         $display("FAIL arb_overrun: got ovr=%b ok=%b expected 1", overrun, ok); errors++;
      end
      wait_step(ok);
      checks++;
      if (!ok || pif.phaseupdown !== 1'b1) begin
         $display("FAIL arb_auto_second: got dir=%b ok=%b expected 1", pif.phaseupdown, ok);
         errors++;
      end
      wait_idle(ok);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || busy !== 1'b0 || position !== 6'(exp_pos)) begin
         $display("FAIL arb_net_position: got pos=%0d busy=%b expected pos=%0d busy=0",
                  position, busy, exp_pos); errors++;
      end
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         $display("FAIL arb_clear: got %b expected 0", overrun); errors++;
      end
   endtask

   task automatic test_timeout();
      bit ok;
      pll_dead = 1'b1;
      pulse_shift();
      repeat (100) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0) begin
         $display("FAIL tmo_early: got busy=%b tmo=%b expected busy=1 tmo=0", busy, timeout_err);
         errors++;
      end
      wait_idle(ok);
      checks++;
      if (!ok || timeout_err !== 1'b1 || position !== 6'(exp_pos)) begin
         $display("FAIL tmo_fire: got tmo=%b pos=%0d ok=%b expected tmo=1 pos=%0d",
                  timeout_err, position, ok, exp_pos); errors++;
      end
      pll_dead = 1'b0;
      pulse_shift();
      wait_idle(ok);
      exp_pos = (exp_pos + 1) % 40;
      checks++;
      if (!ok || position !== 6'(exp_pos)) begin
         $display("FAIL tmo_recover: got pos=%0d ok=%b expected %0d", position, ok, exp_pos);
         errors++;
      end
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         $display("FAIL tmo_clear: got %b expected 0", timeout_err); errors++;
      end
   endtask

   task automatic test_enable();
      bit ok;
      bit seen;
      seen = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pulse_shift();
         repeat (2) begin
            @(negedge clk);
            if (pif.phasestep || busy) seen = 1'b1;
         end
      end
      checks++;
      if (seen !== 1'b0 || overrun !== 1'b0 || position !== 6'(exp_pos)) begin
         $display("FAIL en_gated: got active=%b ovr=%b pos=%0d expected 0 0 %0d",
                  seen, overrun, position, exp_pos); errors++;
      end
      send_cmd(1'b1);
      wait_idle(ok);
      exp_pos = (exp_pos + 1) % 40;
      checks++;
      if (!ok || position !== 6'(exp_pos)) begin
         $display("FAIL en_manual: got pos=%0d ok=%b expected %0d", position, ok, exp_pos);
         errors++;
      end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      pulse_shift();
      @(negedge clk);
      checks++;
      if (pif.phasestep !== 1'b1 || position === 6'd0) begin
         $display("FAIL rst_mid_setup: got step=%b pos=%0d expected step=1 pos!=0",
                  pif.phasestep, position); errors++;
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pif.phasestep !== 1'b0 || position !== 6'd0 || pif.cmd_ready !== 1'b1
          || busy !== 1'b0) begin
         $display("FAIL rst_mid_async: got step=%b pos=%0d rdy=%b busy=%b expected 0 0 1 0",
                  pif.phasestep, position, pif.cmd_ready, busy); errors++;
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      pulse_shift();
      wait_idle(ok);
      checks++;
      if (!ok || position !== 6'd1) begin
         $display("FAIL rst_mid_recover: got pos=%0d ok=%b expected 1", position, ok);
         errors++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_pos = 0;
      pll_dead = 1'b0;
      reset = 1'b1;
      enable = 1'b1;
      shift = 1'b0;
      clr_flags = 1'b0;
      pif.cmd_valid = 1'b0;
      pif.cmd_dir = 1'b0;
      pif.phasedone = 1'b1;
      test_reset();
      test_auto_single();
      test_wrap();
      test_arbitration();
      test_timeout();
      test_enable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
